// File: rtl/parallel_bus_sequencer.sv
// parallel_bus_sequencer: strobe, 4-phase handshake and pin-bus arbitration control for the GPIO FIFO datapath.
// Optional handshake watchdog is built only when PSEQ_TIMEOUT_EN is defined.
module parallel_bus_sequencer #(
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ext_wr_req,
  input  logic ext_rd_req,
  output logic ext_ack,
  output logic bus_oe,
  input  logic host_push_req,
  output logic host_push_gnt,
  input  logic host_pop_req,
  output logic host_pop_gnt,
  input  logic rx_full,
  input  logic rx_empty,
  input  logic tx_full,
  input  logic tx_empty,
  output logic load,
  output logic read,
  output logic write,
  output logic send,
  output logic busy,
  output logic err_timeout
);

  if (SETUP_CYCLES < 1 || TIMEOUT_CYCLES < 2 || CNT_WIDTH < 1) begin : g_param_check
    $error("parallel_bus_sequencer: invalid SETUP_CYCLES/TIMEOUT_CYCLES/CNT_WIDTH");
  end

  // IDLE arbitrate | RX_LOAD load | RX_ACK ack | TX_SEND send+oe | TX_SETUP oe settle | TX_ACK oe+ack | TURN release
  typedef enum logic [2:0] {
    IDLE, RX_LOAD, RX_ACK, TX_SEND, TX_SETUP, TX_ACK, TURN
  } state_t;

  localparam logic [CNT_WIDTH-1:0] SETUP_LAST = CNT_WIDTH'(SETUP_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 wr_meta_q, wr_s_q, rd_meta_q, rd_s_q;
  logic                 rr_last_tx_q, rr_last_tx_d;
  logic [1:0]           push_hold_q, push_hold_d, pop_hold_q, pop_hold_d;
  logic                 load_q, load_d, read_q, read_d, write_q, write_d, send_q, send_d;
  logic                 ext_ack_q, ext_ack_d, bus_oe_q, bus_oe_d, busy_q, busy_d;
  logic                 rx_ok, tx_ok;
`ifdef PSEQ_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  logic                 wait_clear_q, wait_clear_d, err_timeout_q, err_timeout_d;
`endif

  assign rx_ok = wr_s_q & ~rx_full;
  assign tx_ok = rd_s_q & ~tx_empty;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_last_tx_d = rr_last_tx_q;
`ifdef PSEQ_TIMEOUT_EN
    wait_clear_d  = wait_clear_q;
    err_timeout_d = err_timeout_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef PSEQ_TIMEOUT_EN
        if (wait_clear_q) begin
          if (!wr_s_q && !rd_s_q) wait_clear_d = 1'b0;
        end else
`endif
        if (rx_ok && (!tx_ok || rr_last_tx_q)) begin
          state_d      = RX_LOAD;
          rr_last_tx_d = 1'b0;
        end else if (tx_ok) begin
          state_d      = TX_SEND;
          rr_last_tx_d = 1'b1;
        end
      end
      RX_LOAD: begin
        state_d = RX_ACK;
        cnt_d   = '0;
      end
      RX_ACK: begin
        if (!wr_s_q) state_d = IDLE;
`ifdef PSEQ_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d       = TURN;
          err_timeout_d = 1'b1;
          wait_clear_d  = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
`endif
      end
      TX_SEND: begin
        state_d = TX_SETUP;
        cnt_d   = SETUP_LAST;
      end
      TX_SETUP: begin
        if (cnt_q == '0) begin
          state_d = TX_ACK;
          cnt_d   = '0;
        end else cnt_d = cnt_q - 1'b1;
      end
      TX_ACK: begin
        if (!rd_s_q) state_d = TURN;
`ifdef PSEQ_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d       = TURN;
          err_timeout_d = 1'b1;
          wait_clear_d  = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
`endif
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    load_d    = (state_d == RX_LOAD);
    send_d    = (state_d == TX_SEND);
    bus_oe_d  = (state_d == TX_SEND) || (state_d == TX_SETUP) || (state_d == TX_ACK);
    ext_ack_d = (state_d == RX_ACK) || (state_d == TX_ACK);
    busy_d    = (state_d != IDLE);

    write_d     = host_push_req & ~tx_full & (push_hold_q == 2'd0);
    push_hold_d = write_d ? 2'd2 : ((push_hold_q != 2'd0) ? push_hold_q - 2'd1 : 2'd0);
    read_d      = host_pop_req & ~rx_empty & (pop_hold_q == 2'd0);
    pop_hold_d  = read_d ? 2'd2 : ((pop_hold_q != 2'd0) ? pop_hold_q - 2'd1 : 2'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      wr_meta_q     <= 1'b0;
      wr_s_q        <= 1'b0;
      rd_meta_q     <= 1'b0;
      rd_s_q        <= 1'b0;
      rr_last_tx_q  <= 1'b0;
      push_hold_q   <= 2'd0;
      pop_hold_q    <= 2'd0;
      load_q        <= 1'b0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      send_q        <= 1'b0;
      ext_ack_q     <= 1'b0;
      bus_oe_q      <= 1'b0;
      busy_q        <= 1'b0;
`ifdef PSEQ_TIMEOUT_EN
      wait_clear_q  <= 1'b0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_meta_q     <= ext_wr_req;
      wr_s_q        <= wr_meta_q;
      rd_meta_q     <= ext_rd_req;
      rd_s_q        <= rd_meta_q;
      rr_last_tx_q  <= rr_last_tx_d;
      push_hold_q   <= push_hold_d;
      pop_hold_q    <= pop_hold_d;
      load_q        <= load_d;
      read_q        <= read_d;
      write_q       <= write_d;
      send_q        <= send_d;
      ext_ack_q     <= ext_ack_d;
      bus_oe_q      <= bus_oe_d;
      busy_q        <= busy_d;
`ifdef PSEQ_TIMEOUT_EN
      wait_clear_q  <= wait_clear_d;
      err_timeout_q <= err_timeout_d;
`endif
    end
  end

  assign ext_ack       = ext_ack_q;
  assign bus_oe        = bus_oe_q;
  assign load          = load_q;
  assign read          = read_q;
  assign write         = write_q;
  assign send          = send_q;
  assign busy          = busy_q;
  assign host_push_gnt = write_q;
  assign host_pop_gnt  = read_q;
`ifdef PSEQ_TIMEOUT_EN
  assign err_timeout   = err_timeout_q;
`else
  assign err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_parallel_bus_sequencer.sv
// Directed bench for parallel_bus_sequencer: reset, RX/TX handshakes, arbitration, host gating, watchdog.
module tb_parallel_bus_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ext_wr_req = 1'b0, ext_rd_req = 1'b0, host_push_req = 1'b0, host_pop_req = 1'b0;
  logic rx_full = 1'b0, rx_empty = 1'b1, tx_full = 1'b0, tx_empty = 1'b1;
  logic ext_ack, bus_oe, host_push_gnt, host_pop_gnt, load, read, write, send, busy, err_timeout;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  parallel_bus_sequencer #(.SETUP_CYCLES(2), .TIMEOUT_CYCLES(16), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .ext_wr_req(ext_wr_req), .ext_rd_req(ext_rd_req),
    .ext_ack(ext_ack), .bus_oe(bus_oe),
    .host_push_req(host_push_req), .host_push_gnt(host_push_gnt),
    .host_pop_req(host_pop_req), .host_pop_gnt(host_pop_gnt),
    .rx_full(rx_full), .rx_empty(rx_empty), .tx_full(tx_full), .tx_empty(tx_empty),
    .load(load), .read(read), .write(write), .send(send),
    .busy(busy), .err_timeout(err_timeout)
  );

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input int max_cyc, input string tag);
    int n = 0;
    while (ext_ack !== lvl && n < max_cyc) begin
      tick(1);
      n++;
    end
    check_eq(tag, ext_ack, lvl);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_outs_held", |{ext_ack, bus_oe, load, read, write, send, busy, err_timeout,
                                host_push_gnt, host_pop_gnt}, 1'b0);
    rst = 1'b0;
    tick(2);
    check_eq("rst_outs_released", |{ext_ack, bus_oe, load, read, write, send, busy, err_timeout,
                                    host_push_gnt, host_pop_gnt}, 1'b0);

    // RX handshake
    ext_wr_req = 1'b1;
    tick(2);
    check_eq("rx_load_c2", load, 1'b0);
    tick(1);
    check_eq("rx_load_c3", load, 1'b1);
    check_eq("rx_ack_c3", ext_ack, 1'b0);
    check_eq("rx_oe_c3", bus_oe, 1'b0);
    tick(1);
    check_eq("rx_load_c4", load, 1'b0);
    check_eq("rx_ack_c4", ext_ack, 1'b1);
    check_eq("rx_oe_c4", bus_oe, 1'b0);
    tick(3);
    ext_wr_req = 1'b0;
    tick(2);
    check_eq("rx_ack_hold", ext_ack, 1'b1);
    tick(1);
    check_eq("rx_ack_drop", ext_ack, 1'b0);
    check_eq("rx_busy_drop", busy, 1'b0);

    // TX handshake
    tx_empty   = 1'b0;
    ext_rd_req = 1'b1;
    tick(3);
    check_eq("tx_send_c3", send, 1'b1);
    check_eq("tx_oe_c3", bus_oe, 1'b1);
    check_eq("tx_ack_c3", ext_ack, 1'b0);
    tick(1);
    check_eq("tx_send_c4", send, 1'b0);
    check_eq("tx_oe_c4", bus_oe, 1'b1);
    check_eq("tx_ack_c4", ext_ack, 1'b0);
    tick(1);
    check_eq("tx_ack_c5", ext_ack, 1'b0);
    tick(1);
    check_eq("tx_ack_c6", ext_ack, 1'b1);
    check_eq("tx_oe_c6", bus_oe, 1'b1);
    ext_rd_req = 1'b0;
    tick(2);
    check_eq("tx_ack_hold", ext_ack, 1'b1);
    check_eq("tx_oe_hold", bus_oe, 1'b1);
    tick(1);
    check_eq("tx_turn_ack", ext_ack, 1'b0);
    check_eq("tx_turn_oe", bus_oe, 1'b0);
    check_eq("tx_turn_busy", busy, 1'b1);
    tick(1);
    check_eq("tx_idle_busy", busy, 1'b0);

    // Reset in the middle of TX_ACK
    ext_rd_req = 1'b1;
    tick(6);
    check_eq("mid_ack_before_rst", ext_ack, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_oe", bus_oe, 1'b0);
    check_eq("mid_rst_ack", ext_ack, 1'b0);
    check_eq("mid_rst_strobes", |{load, read, write, send}, 1'b0);
    ext_rd_req = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    check_eq("mid_rst_busy_after", busy, 1'b0);

    // Round-robin: both requests raised together each round -> TX, RX, TX, RX
    for (int r = 0; r < 4; r++) begin
      ext_wr_req = 1'b1;
      ext_rd_req = 1'b1;
      wait_ack(1'b1, 20, "arb_ack_hi");
      check_eq($sformatf("arb%0d_is_tx", r), bus_oe, (r % 2 == 0));
      ext_wr_req = 1'b0;
      ext_rd_req = 1'b0;
      wait_ack(1'b0, 20, "arb_ack_lo");
      tick(4);
      check_eq($sformatf("arb%0d_idle", r), busy, 1'b0);
    end

    // Backpressure: rx_full blocks the write side, TX still served
    rx_full    = 1'b1;
    ext_wr_req = 1'b1;
    ext_rd_req = 1'b1;
    wait_ack(1'b1, 20, "bp_tx_ack");
    check_eq("bp_served_tx", bus_oe, 1'b1);
    ext_rd_req = 1'b0;
    wait_ack(1'b0, 20, "bp_tx_release");
    tick(10);
    check_eq("bp_wr_no_ack", ext_ack, 1'b0);
    check_eq("bp_wr_not_busy", busy, 1'b0);
    rx_full = 1'b0;
    tick(2);
    check_eq("bp_wr_ack_after_release", ext_ack, 1'b1);
    check_eq("bp_wr_oe", bus_oe, 1'b0);
    ext_wr_req = 1'b0;
    wait_ack(1'b0, 20, "bp_wr_release");
    tick(2);

    // Host push: one grant every third cycle
    host_push_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick(1);
      check_eq($sformatf("push_gnt_%0d", i), host_push_gnt, (i % 3 == 0));
      check_eq($sformatf("push_write_%0d", i), write, (i % 3 == 0));
    end
    tx_full      = 1'b1;
    host_pop_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check_eq($sformatf("push_full_%0d", i), write, 1'b0);
      check_eq($sformatf("pop_empty_%0d", i), read, 1'b0);
    end
    rx_empty = 1'b0;
    tick(1);
    check_eq("pop_gnt", host_pop_gnt, 1'b1);
    check_eq("pop_read", read, 1'b1);
    tick(1);
    check_eq("pop_read_hold", read, 1'b0);
    host_push_req = 1'b0;
    host_pop_req  = 1'b0;
    tx_full       = 1'b0;
    rx_empty      = 1'b1;
    tick(3);

`ifdef PSEQ_TIMEOUT_EN
    ext_rd_req = 1'b1;
    tick(6);
    check_eq("to_ack_start", ext_ack, 1'b1);
    tick(15);
    check_eq("to_ack_c15", ext_ack, 1'b1);
    check_eq("to_err_c15", err_timeout, 1'b0);
    tick(1);
    check_eq("to_ack_c16", ext_ack, 1'b0);
    check_eq("to_err_c16", err_timeout, 1'b1);
    check_eq("to_oe_c16", bus_oe, 1'b0);
    tick(10);
    check_eq("to_wait_busy", busy, 1'b0);
    check_eq("to_wait_ack", ext_ack, 1'b0);
    ext_rd_req = 1'b0;
    tick(4);
    ext_rd_req = 1'b1;
    wait_ack(1'b1, 20, "to_rearm_ack");
    check_eq("to_err_sticky", err_timeout, 1'b1);
    ext_rd_req = 1'b0;
    wait_ack(1'b0, 20, "to_rearm_release");
`else
    ext_rd_req = 1'b1;
    tick(6);
    check_eq("nto_ack_start", ext_ack, 1'b1);
    tick(30);
    check_eq("nto_ack_held", ext_ack, 1'b1);
    check_eq("nto_oe_held", bus_oe, 1'b1);
    check_eq("nto_err_zero", err_timeout, 1'b0);
    ext_rd_req = 1'b0;
    wait_ack(1'b0, 20, "nto_release");
`endif
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
